scratch_mem_arbiter: RTL

Arbitrates single-port access to the 128-bit histogram scratch memory. The memory is shared between two requesters: the histogram datapath, which does bin read-modify-write, and the CDF/equalization stage, which only reads. The block also contains a clear sequencer that zeroes the histogram region at the start of each image. It sits inside `top_without_mem`, between `histogram_equalizer_core` and the scratch `memory` instance.

---
 rtl/scratch_mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/scratch_mem_arbiter.sv
// Single-port arbiter for the histogram scratch memory: round-robin between the
// histogram RMW port and the read-only CDF port, plus a zeroing clear sequencer.
module scratch_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 128,
    parameter int HIST_WORDS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              hist_req,
    input  logic              hist_we,
    input  logic [ADDR_W-1:0] hist_addr,
    input  logic [DATA_W-1:0] hist_wdata,
    output logic              hist_gnt,
    output logic              hist_rvalid,
    output logic [DATA_W-1:0] hist_rdata,
    input  logic              cdf_req,
    input  logic [ADDR_W-1:0] cdf_addr,
    output logic              cdf_gnt,
    output logic              cdf_rvalid,
    output logic [DATA_W-1:0] cdf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_HIST = 2'd1;
    localparam logic [1:0] TAG_CDF  = 2'd2;

    state_t            state;
    logic              rr_last;      // 1 = CDF was granted last, so hist wins the next tie
    logic [ADDR_W-1:0] clear_cnt;
    logic [1:0]        tag_p1;
    logic [1:0]        tag_p2;
    logic              arb_en;

    // A clear request in IDLE pre-empts any grant in the same cycle.
    assign arb_en   = reset && (state == IDLE) && !clear_start;
    assign hist_gnt = arb_en && hist_req && (!cdf_req || rr_last);
    assign cdf_gnt  = arb_en && cdf_req && (!hist_req || !rr_last);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            clear_cnt   <= '0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_wdata   <= '0;
            tag_p1      <= TAG_NONE;
            tag_p2      <= TAG_NONE;
            hist_rvalid <= 1'b0;
            hist_rdata  <= '0;
            cdf_rvalid  <= 1'b0;
            cdf_rdata   <= '0;
        end else begin
            // Stage p1 -> p2: owner tag follows mem_re while memory produces the data.
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            clear_done <= 1'b0;
            tag_p1     <= TAG_NONE;
            tag_p2     <= tag_p1;

            // Stage p2 -> return: capture mem_rdata for whichever port owns it.
            hist_rvalid <= (tag_p2 == TAG_HIST);
            cdf_rvalid  <= (tag_p2 == TAG_CDF);
            if (tag_p2 == TAG_HIST) hist_rdata <= mem_rdata;
            if (tag_p2 == TAG_CDF)  cdf_rdata  <= mem_rdata;

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                        clear_cnt  <= '0;
                    end else if (hist_gnt) begin
                        rr_last   <= 1'b0;
                        mem_addr  <= hist_addr;
                        mem_we    <= hist_we;
                        mem_re    <= !hist_we;
                        mem_wdata <= hist_wdata;
                        tag_p1    <= hist_we ? TAG_NONE : TAG_HIST;
                    end else if (cdf_gnt) begin
                        rr_last  <= 1'b1;
                        mem_addr <= cdf_addr;
                        mem_re   <= 1'b1;
                        tag_p1   <= TAG_CDF;
                    end
                end
                CLEAR: begin
                    mem_addr  <= clear_cnt;
                    mem_we    <= 1'b1;
                    mem_wdata <= '0;
                    if (clear_cnt == ADDR_W'(HIST_WORDS - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
